tx_ram_ctrl: RTL and testbench
==============================

# tx_ram_ctrl

Single-clock FIFO controller that sequences the 16×70 distributed SDP TX RAM (`tx_ram_0`) as the transmit elastic buffer of the raw 10G link. It sits between the framer (upstream, valid/ready) and the PCS TX gearbox feed (downstream, valid/ready). It owns the RAM write and read ports, the pointers, occupancy and flush. The RAM is instantiated outside this block with both RAM clocks tied to `clk` and its `rst` tied low.

## Interface

Parameters:
- `ADDR_WIDTH`, default 4: RAM address width; buffer depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 70: word width (64 data, 2 sync header, 4 control flags; opaque to this block).
- `AFULL_THRESH`, default 12: `almost_full` asserts when `level` ≥ this value. Legal range is 1..2^ADDR_WIDTH.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous clear of the buffer contents.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  upstream may transfer.
- `s_data`  in  DATA_WIDTH  upstream word.
- `m_valid`  out  1  downstream word valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  downstream word.
- `ram_wr_en`  out  1  RAM write enable.
- `ram_wr_addr`  out  ADDR_WIDTH  RAM write address.
- `ram_wr_data`  out  DATA_WIDTH  RAM write data.
- `ram_rd_addr`  out  ADDR_WIDTH  RAM read address.
- `ram_rd_data`  in  DATA_WIDTH  RAM read data; combinational from `ram_rd_addr`.
- `level`  out  ADDR_WIDTH+1  number of words held in the RAM.
- `almost_full`  out  1  registered; high while `level` ≥ AFULL_THRESH.

## Operation

- **Pointers.** `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the lower bits are equal.
  - `level` = `wr_ptr` − `rd_ptr`, computed modulo 2^(ADDR_WIDTH+1).
- **Write side.**
  - `s_ready` = !full & !flush.
  - push = `s_valid` & `s_ready`.
  - `ram_wr_en` = push.
  - `ram_wr_addr` = `wr_ptr`[ADDR_WIDTH-1:0].
  - `ram_wr_data` = `s_data`.
  - `wr_ptr` increments on push.
- **Read side (base).**
  - `ram_rd_addr` = `rd_ptr`[ADDR_WIDTH-1:0].
  - `m_valid` = !empty.
  - `m_data` = `ram_rd_data`.
  - pop = `m_valid` & `m_ready` & !flush; `rd_ptr` increments on pop.
- **Simultaneous push and pop:** both pointers advance and `level` is unchanged.
- **Full:** `s_ready` is 0 even if a pop occurs in the same cycle; there is no write-through when full.
- **Empty:** a push does not bypass to `m_data` in the same cycle.
- **`m_data` stability:** `m_data` stays constant while `m_valid` & !`m_ready`. This holds because a write never targets the head slot while the buffer is non-empty.
- **Flush:**
  - Next edge: `wr_ptr` = `rd_ptr` = 0, `level` = 0, output stage emptied.
  - Flush-cycle push is blocked (`s_ready` = 0) and pop is suppressed.
  - RAM contents are not cleared.
- **Reset values (`rst_n` low):**
  - Pointers 0, so `level` 0 and `almost_full` 0.
  - `m_valid` 0, `s_ready` 1 (0 if `flush` is high), `ram_wr_en` 0 (given `s_valid` low).
  - Both RAM addresses 0, and the output register (if present) is 0.
- **Reset mid-operation:** all buffered words are lost. No partial state survives.

## Timing

- Write→`m_valid` latency (base): 1 cycle. A word pushed at edge N gives `m_valid` = 1 in the cycle after edge N.
- Throughput: 1 word per cycle in each direction, sustained.
- `almost_full` is registered from the next-state `level`. It therefore changes in the same cycle as `level`.
- Combinational paths in the base build: `s_valid` → `ram_wr_en`, `m_ready` → none (pop only affects registers), `ram_rd_data` → `m_data`.

## Configuration

- Macro `TX_RAM_CTRL_OUT_REG_EN`.
- **Defined:** a one-word output register is added after the RAM read.
  - `m_valid` and `m_data` are registers.
  - load = !empty & (!`m_valid` | `m_ready`) & !flush. On load, the register takes `ram_rd_data` and `rd_ptr` increments.
  - `m_valid` clears on `m_ready` when no load occurs.
  - Write→`m_valid` latency is 2 cycles. Throughput is still 1 word per cycle.
  - `level` counts RAM words only, so total capacity is 2^ADDR_WIDTH+1.
- **Undefined:** base behaviour as above; `m_data` is combinational from the RAM.

## Test plan

- **Reset and single word:** release reset, push 70'h2_0123456789ABCDEF_3 with `m_ready` = 0. Expect `m_valid` = 1 one cycle later (two with the macro) with `m_data` equal to that word, and `level` = 1 (0 with the macro once the word is loaded).
- **Fill to full:** push 16 words 0..15 with `m_ready` = 0. Expect `almost_full` to rise after the 12th push, `s_ready` = 0 after the 16th push, the 17th push ignored, and `level` = 16.
- **Full with simultaneous pop:** from full, assert `s_valid` and `m_ready` for one cycle. Expect one word popped (value 0), no push, and `level` = 15.
- **Streaming wrap:** push 40 incrementing words while `m_ready` = 1 continuously. Expect output order 0..39 with no gaps after the first valid, `level` ≤ 1, and both pointers wrapping twice.
- **Flush:** with `level` = 7, assert `flush` for 1 cycle while `s_valid` = 1. Expect `s_ready` = 0 in that cycle, `level` = 0 and `m_valid` = 0 next cycle, and the next push reading back first.
- **Async reset mid-stream:** pulse `rst_n` low asynchronously for 3 ns while `level` = 5. Expect `level` = 0, `m_valid` = 0 and `almost_full` = 0 immediately, with normal operation on the next push.

Source files
------------

// File: rtl/tx_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tx_ram_ctrl
//
// FIFO controller for the 16x70 distributed SDP TX RAM used as the transmit
// elastic buffer of the raw 10G link. It sits between the framer (upstream
// valid/ready) and the PCS TX gearbox feed (downstream valid/ready), and owns
// the RAM write/read ports, the pointers, occupancy and flush. The RAM lives
// outside this block; its read data is combinational from ram_rd_addr.
//
// Ports:
//   clk, rst_n         single clock, asynchronous active-low reset
//   flush              synchronous clear: pointers to 0, output stage emptied
//   s_valid/s_ready/s_data   upstream word interface
//   m_valid/m_ready/m_data   downstream word interface
//   ram_wr_en/ram_wr_addr/ram_wr_data   RAM write port
//   ram_rd_addr/ram_rd_data             RAM read port
//   level              words held in the RAM (wr_ptr - rd_ptr)
//   almost_full        registered, high while level >= AFULL_THRESH
//
// Build option:
//   TX_RAM_CTRL_OUT_REG_EN  adds a one-word output register after the RAM
//                           read (m_valid/m_data registered, 2-cycle latency).
// ---------------------------------------------------------------------------
module tx_ram_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 70,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic          empty, full, push, rd_adv;

  // One extra pointer bit distinguishes full (MSBs differ) from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  // No write-through when full: s_ready ignores a same-cycle pop so the
  // ready path stays short and the head slot is never overwritten.
  assign s_ready     = !full && !flush;
  assign push        = s_valid && s_ready;
  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = s_data;
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign level       = wr_ptr - rd_ptr;

`ifdef TX_RAM_CTRL_OUT_REG_EN
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  load;

  // Refill the output register whenever it is empty or being drained.
  assign load    = !empty && (!m_valid_q || m_ready) && !flush;
  assign rd_adv  = load;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (flush) begin
      // Only the valid flag is cleared; stale data is harmless once invalid.
      m_valid_q <= 1'b0;
    end else if (load) begin
      m_valid_q <= 1'b1;
      m_data_q  <= ram_rd_data;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end
`else
  // Head word is presented straight from the RAM; a push into an empty
  // buffer becomes visible only after the write edge (no bypass).
  assign m_valid = !empty;
  assign m_data  = ram_rd_data;
  assign rd_adv  = m_valid && m_ready && !flush;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push)   wr_ptr_nxt = wr_ptr + PW'(1);
      if (rd_adv) rd_ptr_nxt = rd_ptr + PW'(1);
    end
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  // almost_full is computed from the next-state level so it moves in the
  // same cycle as level while still being a clean register output.
  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the RAM array is external and is deliberately never cleared;
  //       resetting the pointers is enough to discard its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      almost_full <= (level_nxt >= AFULL_LVL);
    end
  end

endmodule

// File: tb/tb_tx_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_ram_ctrl
//
// Bench for tx_ram_ctrl in its default build. A small behavioural SDP RAM
// (synchronous write, combinational read) stands in for tx_ram_0. Inputs are
// driven on the falling edge and outputs sampled 1 ns later, so every
// expected value describes the state before the following rising edge.
// ---------------------------------------------------------------------------
module tb_tx_ram_ctrl;

  localparam int AW = 4;
  localparam int DW = 70;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [AW:0]   level;
  logic          almost_full;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .level(level), .almost_full(almost_full)
  );

  // Behavioural stand-in for the external distributed RAM.
  logic [DW-1:0] mem [1<<AW];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [DW-1:0] sd,
                       input logic mr, input logic fl);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
  endtask

  typedef struct {
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_ready;
    logic          flush;
    logic          exp_s_ready;
    logic          exp_wr_en;
    logic          exp_m_valid;
    logic          chk_data;
    logic [DW-1:0] exp_m_data;
    logic [AW:0]   exp_level;
    logic          exp_afull;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [DW-1:0] sd,
                              input logic mr, input logic fl,
                              input logic e_rdy, input logic e_wen,
                              input logic e_mv, input logic cd,
                              input logic [DW-1:0] e_md, input int e_lvl,
                              input logic e_af);
    vec_t v;
    v.s_valid = sv; v.s_data = sd; v.m_ready = mr; v.flush = fl;
    v.exp_s_ready = e_rdy; v.exp_wr_en = e_wen; v.exp_m_valid = e_mv;
    v.chk_data = cd; v.exp_m_data = e_md; v.exp_level = (AW+1)'(e_lvl);
    v.exp_afull = e_af;
    return v;
  endfunction

  vec_t tbl[$];
  logic [DW-1:0] w0;

  initial begin
    w0 = 70'h2_0123456789ABCDEF_3;

    // Single word, then a 7-deep buffer flushed while upstream is pushing.
    tbl.push_back(mk(1, w0, 0, 0, 1, 1, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 1, 0, 1, 1, w0, 1, 0));
    tbl.push_back(mk(0, '0, 1, 0, 1, 0, 1, 1, w0, 1, 0));
    tbl.push_back(mk(0, '0, 0, 0, 1, 0, 0, 0, '0, 0, 0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(1, DW'(200 + k), 0, 0, 1, 1, k > 0, k > 0, DW'(200), k, 0));
    tbl.push_back(mk(1, DW'(999), 1, 1, 0, 0, 1, 1, DW'(200), 7, 0));
    tbl.push_back(mk(0, '0, 0, 0, 1, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(1, DW'(300), 0, 0, 1, 1, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, '0, 0, 0, 1, 0, 1, 1, DW'(300), 1, 0));
    tbl.push_back(mk(0, '0, 1, 0, 1, 0, 1, 1, DW'(300), 1, 0));
    tbl.push_back(mk(0, '0, 0, 0, 1, 0, 0, 0, '0, 0, 0));

    // ---- Reset state ----
    #12;
    check("rst_s_ready", DW'(s_ready), DW'(1));
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_level", DW'(level), DW'(0));
    check("rst_afull", DW'(almost_full), DW'(0));
    check("rst_wr_en", DW'(ram_wr_en), DW'(0));
    check("rst_wr_addr", DW'(ram_wr_addr), DW'(0));
    check("rst_rd_addr", DW'(ram_rd_addr), DW'(0));
    flush = 1'b1;
    #1;
    check("rst_flush_s_ready", DW'(s_ready), DW'(0));
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Table-driven vectors ----
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s_valid, tbl[i].s_data, tbl[i].m_ready, tbl[i].flush);
      check($sformatf("v%0d_s_ready", i), DW'(s_ready), DW'(tbl[i].exp_s_ready));
      check($sformatf("v%0d_wr_en", i), DW'(ram_wr_en), DW'(tbl[i].exp_wr_en));
      check($sformatf("v%0d_m_valid", i), DW'(m_valid), DW'(tbl[i].exp_m_valid));
      check($sformatf("v%0d_level", i), DW'(level), DW'(tbl[i].exp_level));
      check($sformatf("v%0d_afull", i), DW'(almost_full), DW'(tbl[i].exp_afull));
      if (tbl[i].chk_data)
        check($sformatf("v%0d_m_data", i), m_data, tbl[i].exp_m_data);
    end

    // ---- Fill to full, 17th push ignored ----
    for (int k = 0; k < 16; k++) begin
      drive(1, DW'(k), 0, 0);
      check($sformatf("fill%0d_s_ready", k), DW'(s_ready), DW'(1));
      check($sformatf("fill%0d_wr_en", k), DW'(ram_wr_en), DW'(1));
      check($sformatf("fill%0d_level", k), DW'(level), DW'(k));
      check($sformatf("fill%0d_afull", k), DW'(almost_full), DW'(k >= 12));
      if (k > 0) check($sformatf("fill%0d_m_data", k), m_data, DW'(0));
    end
    drive(1, DW'(99), 0, 0);
    check("full_s_ready", DW'(s_ready), DW'(0));
    check("full_wr_en", DW'(ram_wr_en), DW'(0));
    check("full_level", DW'(level), DW'(16));
    check("full_afull", DW'(almost_full), DW'(1));

    // ---- Full with simultaneous pop: pop only ----
    drive(1, DW'(77), 1, 0);
    check("fullpop_s_ready", DW'(s_ready), DW'(0));
    check("fullpop_wr_en", DW'(ram_wr_en), DW'(0));
    check("fullpop_m_valid", DW'(m_valid), DW'(1));
    check("fullpop_m_data", m_data, DW'(0));
    for (int k = 1; k < 16; k++) begin
      drive(0, '0, 1, 0);
      check($sformatf("drain%0d_m_valid", k), DW'(m_valid), DW'(1));
      check($sformatf("drain%0d_m_data", k), m_data, DW'(k));
      check($sformatf("drain%0d_level", k), DW'(level), DW'(16 - k));
      check($sformatf("drain%0d_afull", k), DW'(almost_full), DW'((16 - k) >= 12));
    end

    // ---- Streaming 40 words with m_ready held high ----
    for (int i = 0; i < 40; i++) begin
      drive(1, DW'(i), 1, 0);
      check($sformatf("strm%0d_s_ready", i), DW'(s_ready), DW'(1));
      check($sformatf("strm%0d_m_valid", i), DW'(m_valid), DW'(i > 0));
      check($sformatf("strm%0d_level", i), DW'(level), DW'(i > 0));
      if (i > 0) check($sformatf("strm%0d_m_data", i), m_data, DW'(i - 1));
    end
    drive(0, '0, 1, 0);
    check("strm_last_m_data", m_data, DW'(39));
    check("strm_last_level", DW'(level), DW'(1));
    drive(0, '0, 0, 0);
    check("strm_end_m_valid", DW'(m_valid), DW'(0));
    check("strm_end_level", DW'(level), DW'(0));

    // ---- Async reset mid-stream with level 5 ----
    for (int k = 0; k < 5; k++) drive(1, DW'(400 + k), 0, 0);
    drive(0, '0, 0, 0);
    check("prerst_level", DW'(level), DW'(5));
    check("prerst_m_data", m_data, DW'(400));
    #1 rst_n = 1'b0;
    #1;
    check("arst_level", DW'(level), DW'(0));
    check("arst_m_valid", DW'(m_valid), DW'(0));
    check("arst_afull", DW'(almost_full), DW'(0));
    #2 rst_n = 1'b1;
    drive(1, DW'(500), 0, 0);
    check("postrst_push_level", DW'(level), DW'(0));
    check("postrst_push_wr_addr", DW'(ram_wr_addr), DW'(0));
    drive(0, '0, 0, 0);
    check("postrst_m_valid", DW'(m_valid), DW'(1));
    check("postrst_m_data", m_data, DW'(500));
    check("postrst_level", DW'(level), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
